// File: rtl/seq_detect_pkg.sv
// Shared types and width helpers for the programmable sequence detector.
package seq_detect_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2
    } state_t;

    // Smallest r with 2**r >= v.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    // Width needed to hold a length value in 0..max_len.
    function automatic int unsigned len_w(input int unsigned max_len);
        return clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/seq_hist_sreg.sv
// History shift register with a saturating count of valid bits shifted in.
module seq_hist_sreg
    import seq_detect_pkg::*;
#(
    parameter int unsigned MAX_LEN = 32,
    parameter int unsigned LEN_W   = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clr,
    input  logic               fill_clr,
    input  logic               in,
    output logic [MAX_LEN-1:0] hist_nxt,
    output logic [LEN_W-1:0]   fill_nxt
);

    logic [MAX_LEN-1:0] hist;
    logic [LEN_W-1:0]   fill;

    assign hist_nxt = {hist[MAX_LEN-2:0], in};
    assign fill_nxt = (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist <= '0;
            fill <= '0;
        end else if (clr) begin
            hist <= '0;
            fill <= '0;
        end else if (en) begin
            hist <= hist_nxt;
            fill <= fill_clr ? '0 : fill_nxt;
        end
    end

endmodule

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial sequence detector with masked compare,
// overlap control and a saturating match counter.
module seq_detect_prog
    import seq_detect_pkg::*;
#(
    parameter string       ARCHITECTURE = "BEHAVIORAL",
    parameter int unsigned MAX_LEN      = 32,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        in,
    input  logic                        cfg_load,
    input  logic [MAX_LEN-1:0]          cfg_pattern,
    input  logic [MAX_LEN-1:0]          cfg_mask,
    input  logic [len_w(MAX_LEN)-1:0]   cfg_len,
    input  logic                        cfg_overlap,
    input  logic                        cnt_clr,
    output logic                        match,
    output logic [CNT_WIDTH-1:0]        match_count,
    output logic                        armed
);

    localparam int unsigned LEN_W = len_w(MAX_LEN);

    // Any other architecture name falls back to the behavioural model below.
    if (ARCHITECTURE != "BEHAVIORAL") begin : g_arch_fallback
    end

    state_t               state, state_nxt;
    logic [MAX_LEN-1:0]   pat_q, mask_q, lenmask, hist_nxt;
    logic [LEN_W-1:0]     len_q, fill_nxt;
    logic                 ovl_q;
    logic                 shift_en, len_ok, enough, hit, match_d, fill_clr;
    logic                 match_q, armed_q;
    logic [CNT_WIDTH-1:0] cnt_q;

    // A bit arriving with cfg_load is dropped so detection restarts cleanly.
    assign shift_en = en & ~cfg_load;
    assign len_ok   = (cfg_len != '0) && (32'(cfg_len) <= MAX_LEN);

    seq_hist_sreg #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_hist (
        .clk      (clk),
        .rst      (rst),
        .en       (shift_en),
        .clr      (cfg_load),
        .fill_clr (fill_clr),
        .in       (in),
        .hist_nxt (hist_nxt),
        .fill_nxt (fill_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q  <= '0;
            mask_q <= '0;
            len_q  <= '0;
            ovl_q  <= 1'b0;
        end else if (cfg_load) begin
            pat_q  <= cfg_pattern;
            mask_q <= cfg_mask;
            len_q  <= cfg_len;
            ovl_q  <= cfg_overlap;
        end
    end

    always_comb begin
        lenmask = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            lenmask[i] = (i < 32'(len_q));
        end
    end

    assign hit      = (((hist_nxt ^ pat_q) & mask_q & lenmask) == '0);
    assign enough   = (fill_nxt >= len_q);
    assign match_d  = shift_en && (state != IDLE) && enough && hit;
    assign fill_clr = match_d && !ovl_q;

    always_comb begin
        state_nxt = state;
        if (cfg_load) begin
            state_nxt = len_ok ? FILL : IDLE;
        end else if (shift_en && (state != IDLE)) begin
            if (fill_clr)    state_nxt = FILL;
            else if (enough) state_nxt = ARMED;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            match_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            match_q <= match_d;
            armed_q <= (state_nxt == ARMED);
        end
    end

    // Clear wins over a coinciding match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (match_d && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    assign match       = match_q;
    assign match_count = cnt_q;
    assign armed       = armed_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed bench for seq_detect_prog: per-bit expectations queued at drive time, checked after the edge.
module tb_seq_detect_prog;

    logic        clk = 1'b0;
    logic        rst, en, in, cfg_load, cfg_overlap, cnt_clr;
    logic [31:0] cfg_pattern, cfg_mask;
    logic [5:0]  cfg_len;
    logic        match, armed;
    logic [1:0]  match_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      tag;
        logic       m;
        logic [1:0] c;
    } exp_t;

    exp_t       sb[$];
    logic [1:0] exp_cnt;

    always #5 clk = ~clk;

    seq_detect_prog #(
        .ARCHITECTURE ("BEHAVIORAL"),
        .MAX_LEN      (32),
        .CNT_WIDTH    (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .in          (in),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_mask    (cfg_mask),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cnt_clr     (cnt_clr),
        .match       (match),
        .match_count (match_count),
        .armed       (armed)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic b, input logic e, input logic expm, input string tag);
        exp_t x;
        @(negedge clk);
        en = e;
        in = b;
        if (cnt_clr)           exp_cnt = 2'd0;
        else if (e && expm)    exp_cnt = (exp_cnt == 2'd3) ? 2'd3 : exp_cnt + 2'd1;
        x.tag = tag;
        x.m   = expm;
        x.c   = exp_cnt;
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        chk({x.tag, "/match"}, match, x.m);
        chk({x.tag, "/count"}, match_count, x.c);
        en      = 1'b0;
        cnt_clr = 1'b0;
    endtask

    task automatic feed(input logic [31:0] bits, input int n, input logic [31:0] expm,
                        input logic gaps, input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            step(bits[i], 1'b1, expm[i], tag);
            if (gaps) step(~bits[i], 1'b0, 1'b0, {tag, "/gap"});
        end
    endtask

    task automatic load(input logic [31:0] pat, input logic [31:0] msk, input logic [5:0] len,
                        input logic ovl, input logic junk);
        @(negedge clk);
        cfg_pattern = pat;
        cfg_mask    = msk;
        cfg_len     = len;
        cfg_overlap = ovl;
        cfg_load    = 1'b1;
        en          = junk;
        in          = junk;
        @(posedge clk);
        #1;
        chk("load/match", match, 1'b0);
        chk("load/armed", armed, 1'b0);
        cfg_load    = 1'b0;
        en          = 1'b0;
        // Scramble the cfg inputs; they must be ignored outside cfg_load.
        cfg_pattern = '1;
        cfg_mask    = '0;
        cfg_len     = 6'd3;
        cfg_overlap = ~ovl;
    endtask

    task automatic clear_count();
        @(negedge clk);
        cnt_clr = 1'b1;
        exp_cnt = 2'd0;
        @(posedge clk);
        #1;
        chk("clr/count", match_count, 2'd0);
        cnt_clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; in = 1'b0; cfg_load = 1'b0; cfg_overlap = 1'b0;
        cnt_clr = 1'b0; cfg_pattern = '0; cfg_mask = '0; cfg_len = '0;
        exp_cnt = 2'd0;
        #12;
        chk("reset/match", match, 1'b0);
        chk("reset/count", match_count, 2'd0);
        chk("reset/armed", armed, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // 1: overlapping, matches after bits 4 and 7
        load(32'hB, 32'hF, 6'd4, 1'b1, 1'b0);
        feed(32'b1011011, 7, 32'b0001001, 1'b0, "t1");
        chk("t1/count_end", match_count, 2'd2);
        chk("t1/armed", armed, 1'b1);

        // 2: non-overlapping, single match, armed stays low while refilling
        clear_count();
        load(32'hB, 32'hF, 6'd4, 1'b0, 1'b0);
        feed(32'b1011, 4, 32'b0001, 1'b0, "t2a");
        chk("t2/armed_after_match", armed, 1'b0);
        feed(32'b011, 3, 32'b000, 1'b0, "t2b");
        chk("t2/armed_refill", armed, 1'b0);
        chk("t2/count_end", match_count, 2'd1);

        // 3: len 8, low nibble masked off
        clear_count();
        load(32'hA5, 32'hF0, 6'd8, 1'b1, 1'b0);
        feed(32'hA3, 8, 32'h01, 1'b0, "t3a");
        feed(32'hB5, 8, 32'h00, 1'b0, "t3b");
        chk("t3/count_end", match_count, 2'd1);

        // 4: test 1 stream with en=0 gaps (inverted in during gaps)
        clear_count();
        load(32'hB, 32'hF, 6'd4, 1'b1, 1'b0);
        feed(32'b1011011, 7, 32'b0001001, 1'b1, "t4");
        chk("t4/count_end", match_count, 2'd2);

        // 5: 2-bit counter saturates, then clear wins over a coinciding match
        clear_count();
        load(32'hB, 32'hF, 6'd4, 1'b1, 1'b0);
        feed(32'hB6DB, 16, 32'h1249, 1'b0, "t5");
        chk("t5/count_sat", match_count, 2'd3);
        step(1'b0, 1'b1, 1'b0, "t5c");
        step(1'b1, 1'b1, 1'b0, "t5c");
        cnt_clr = 1'b1;
        step(1'b1, 1'b1, 1'b1, "t5clr");
        chk("t5/count_clr", match_count, 2'd0);

        // 6: async reset mid-stream, disabled length, reload discards history
        load(32'hB, 32'hF, 6'd4, 1'b1, 1'b0);
        feed(32'b1011101, 7, 32'b0001000, 1'b0, "t6a");
        chk("t6/armed_pre", armed, 1'b1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6/rst_match", match, 1'b0);
        chk("t6/rst_count", match_count, 2'd0);
        chk("t6/rst_armed", armed, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 2'd0;
        step(1'b1, 1'b1, 1'b0, "t6post");
        load(32'hB, 32'hF, 6'd0, 1'b1, 1'b0);
        feed(32'b1011, 4, 32'b0000, 1'b0, "t6len0");
        chk("t6/len0_armed", armed, 1'b0);
        load(32'hB, 32'hF, 6'd4, 1'b1, 1'b0);
        feed(32'b10, 2, 32'b00, 1'b0, "t6pre");
        load(32'hB, 32'hF, 6'd4, 1'b1, 1'b1);
        feed(32'b111011, 6, 32'b000001, 1'b0, "t6reload");
        chk("t6/count_end", match_count, 2'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
